pipeline_hazard_ctrl: RTL and testbench
=======================================

PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset: clk  in  1  rising-edge clock; reset_n  in  1  asynchronous reset, active low.
REQ-002 The block SHALL have inputs: id_rs1  in  5  ID-stage source 1; id_rs2  in  5  ID-stage source 2; id_use_rs1  in  1  rs1 read valid; id_use_rs2  in  1  rs2 read valid.
REQ-003 The block SHALL have inputs: ex_rd  in  5  EX-stage destination; ex_memread  in  1  EX holds a load; ex_branch_taken  in  1  EX resolved a taken branch.
REQ-004 The block SHALL have inputs: mem_req  in  1  MEM stage accesses data memory; mem_ready  in  1  data memory completes the access this cycle.
REQ-005 The block SHALL have outputs: pc_write  out  1  PC update enable; if_id_write  out  1  IF/ID load enable; if_id_flush  out  1  IF/ID clear to NOP; id_ex_stall  out  1  ID/EX bubble (controls zeroed); pipe_freeze  out  1  hold ID/EX, EX/MEM, MEM/WB; state  out  2  current FSM state.

Function
REQ-006 The FSM SHALL have states RUN=2'd0, MEM_WAIT=2'd1 and REDIRECT=2'd2; code 2'd3 SHALL return to RUN on the next edge with all outputs in their RUN defaults.
REQ-007 Outputs SHALL be combinational from the registered state and the current inputs (Mealy), with zero-cycle latency from hazard input to control output.
REQ-008 The RUN defaults SHALL be: pc_write=1, if_id_write=1, if_id_flush=0, id_ex_stall=0, pipe_freeze=0.
REQ-009 A load-use hazard SHALL be ex_memread=1 and ex_rd!=0 and ((id_use_rs1=1 and id_rs1==ex_rd) or (id_use_rs2=1 and id_rs2==ex_rd)).
REQ-010 In RUN with a load-use hazard only, the block SHALL drive pc_write=0, if_id_write=0 and id_ex_stall=1 for exactly that cycle, with no state change.
REQ-011 In RUN with ex_branch_taken=1, the block SHALL drive if_id_flush=1, id_ex_stall=1 and pc_write=1, and SHALL suppress any load-use response in the same cycle.
REQ-012 In RUN with mem_req=1 and mem_ready=0, the block SHALL go to MEM_WAIT and SHALL drive pipe_freeze=1, pc_write=0 and if_id_write=0 in that cycle, overriding REQ-010 and REQ-011.
REQ-013 If ex_branch_taken=1 in the cycle RUN goes to MEM_WAIT, a pending_flush flag SHALL be set.
REQ-014 In MEM_WAIT, the block SHALL drive pipe_freeze=1, pc_write=0 and if_id_write=0 until mem_ready=1.
REQ-015 When mem_ready=1 in MEM_WAIT, the block SHALL go to REDIRECT if pending_flush=1, otherwise to RUN; outputs in that cycle SHALL still be frozen.
REQ-016 In REDIRECT, the block SHALL drive if_id_flush=1, id_ex_stall=1 and pc_write=1 for one cycle, clear pending_flush, and return to RUN.
REQ-017 mem_req=1 together with mem_ready=1 in the same RUN cycle SHALL cause no freeze.
REQ-018 ex_rd=0 SHALL never create a hazard.
REQ-019 Inputs SHALL be ignored in REDIRECT, except that a new mem_req=1 with mem_ready=0 SHALL go to MEM_WAIT after the flush cycle.

Reset
REQ-020 When reset_n=0, the block SHALL asynchronously set state=RUN and pending_flush=0; outputs SHALL take the RUN defaults, and any counters SHALL be 0.
REQ-021 Reset asserted in MEM_WAIT or REDIRECT SHALL discard the pending freeze and pending flush.

Configuration
REQ-022 With HAZARD_PERF_CNT_EN defined, the block SHALL add 32-bit outputs stall_cnt (load-use cycles), freeze_cnt (cycles with pipe_freeze=1) and flush_cnt (cycles with if_id_flush=1), each saturating at 32'hFFFF_FFFF.
REQ-023 Without HAZARD_PERF_CNT_EN, those ports and registers SHALL be absent and the remaining behaviour SHALL be identical.

Structure
REQ-024 The state encoding localparams and the register-index width (5) SHALL live in the shared package pipe_ctrl_pkg.
REQ-025 Load-use detection SHALL be a combinational sub-module, hazard_detect, with outputs load_use; the FSM and counters SHALL stay in the top module.

Verification
REQ-026 Load-use: ex_memread=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> pc_write=0, if_id_write=0, id_ex_stall=1 for one cycle, state=0.
REQ-027 x0 load: ex_memread=1, ex_rd=0, id_rs1=0, id_use_rs1=1 -> RUN defaults.
REQ-028 Branch+load-use: ex_branch_taken=1 together with REQ-026 inputs -> if_id_flush=1, id_ex_stall=1, pc_write=1.
REQ-029 Memory wait: mem_req=1, mem_ready=0 for 3 cycles, then 1 -> pipe_freeze=1 for 4 cycles, state=1 for 3 cycles, then RUN.
REQ-030 Branch into wait: ex_branch_taken=1, mem_req=1, mem_ready=0, then mem_ready=1 after 2 cycles -> state 1 (2 cycles), then 2 with if_id_flush=1 for one cycle, then 0.
REQ-031 Reset in MEM_WAIT: reset_n=0 mid-wait -> state=0 immediately; after release with mem_req=0 -> no flush; with HAZARD_PERF_CNT_EN, counters=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state codes
// and register-index width.
package pipe_ctrl_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [1:0] RUN_CODE      = 2'd0;
  localparam logic [1:0] MEM_WAIT_CODE = 2'd1;
  localparam logic [1:0] REDIRECT_CODE = 2'd2;
  localparam logic [1:0] UNUSED_CODE   = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN      = RUN_CODE,
    ST_MEM_WAIT = MEM_WAIT_CODE,
    ST_REDIRECT = REDIRECT_CODE,
    ST_UNUSED   = UNUSED_CODE
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use detector: a load in EX whose non-zero destination
// is read by the instruction in ID.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_memread,
  output logic                 load_use
);

  logic w_rd_nonzero;
  logic w_rs1_hit;
  logic w_rs2_hit;

  assign w_rd_nonzero = (ex_rd != {REG_IDX_W{1'b0}});
  assign w_rs1_hit    = id_use_rs1 && (id_rs1 == ex_rd);
  assign w_rs2_hit    = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use     = ex_memread && w_rd_nonzero && (w_rs1_hit || w_rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush and data-memory
// freeze. Define HAZARD_PERF_CNT_EN to add saturating performance counters.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [REG_IDX_W-1:0] id_rs1,
  input  logic [REG_IDX_W-1:0] id_rs2,
  input  logic                 id_use_rs1,
  input  logic                 id_use_rs2,
  input  logic [REG_IDX_W-1:0] ex_rd,
  input  logic                 ex_memread,
  input  logic                 ex_branch_taken,
  input  logic                 mem_req,
  input  logic                 mem_ready,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0]          stall_cnt,
  output logic [31:0]          freeze_cnt,
  output logic [31:0]          flush_cnt,
`endif
  output logic                 pc_write,
  output logic                 if_id_write,
  output logic                 if_id_flush,
  output logic                 id_ex_stall,
  output logic                 pipe_freeze,
  output logic [1:0]           state
);

  state_t r_state;
  state_t w_next;
  logic   r_pending_flush;
  logic   w_pending_next;
  logic   w_load_use;
  logic   w_mem_stall;

  hazard_detect u_hazard_detect (
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .ex_rd      (ex_rd),
    .ex_memread (ex_memread),
    .load_use   (w_load_use)
  );

  assign w_mem_stall = mem_req && !mem_ready;
  assign state       = r_state;

  // Mealy outputs; a memory stall outranks a branch flush, which outranks load-use.
  always_comb begin
    pc_write       = 1'b1;
    if_id_write    = 1'b1;
    if_id_flush    = 1'b0;
    id_ex_stall    = 1'b0;
    pipe_freeze    = 1'b0;
    w_next         = r_state;
    w_pending_next = r_pending_flush;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          pipe_freeze    = 1'b1;
          pc_write       = 1'b0;
          if_id_write    = 1'b0;
          w_next         = ST_MEM_WAIT;
          w_pending_next = ex_branch_taken;
        end else if (ex_branch_taken) begin
          if_id_flush = 1'b1;
          id_ex_stall = 1'b1;
        end else if (w_load_use) begin
          pc_write    = 1'b0;
          if_id_write = 1'b0;
          id_ex_stall = 1'b1;
        end else begin
          w_next = ST_RUN;
        end
      end
      ST_MEM_WAIT: begin
        pipe_freeze = 1'b1;
        pc_write    = 1'b0;
        if_id_write = 1'b0;
        if (mem_ready) begin
          w_next = r_pending_flush ? ST_REDIRECT : ST_RUN;
        end else begin
          w_next = ST_MEM_WAIT;
        end
      end
      ST_REDIRECT: begin
        if_id_flush    = 1'b1;
        id_ex_stall    = 1'b1;
        w_pending_next = 1'b0;
        w_next         = w_mem_stall ? ST_MEM_WAIT : ST_RUN;
      end
      default: begin
        w_next         = ST_RUN;
        w_pending_next = 1'b0;
      end
    endcase
  end

  // State and deferred-flush registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= ST_RUN;
      r_pending_flush <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_pending_flush <= w_pending_next;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_freeze_cnt;
  logic [31:0] r_flush_cnt;
  logic        w_stall_evt;

  // A stall without a flush is the load-use response.
  assign w_stall_evt = id_ex_stall && !if_id_flush;

  // Saturating event counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt  <= 32'd0;
      r_freeze_cnt <= 32'd0;
      r_flush_cnt  <= 32'd0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
      if (pipe_freeze && (r_freeze_cnt != 32'hFFFF_FFFF)) begin
        r_freeze_cnt <= r_freeze_cnt + 32'd1;
      end
      if (if_id_flush && (r_flush_cnt != 32'hFFFF_FFFF)) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign stall_cnt  = r_stall_cnt;
  assign freeze_cnt = r_freeze_cnt;
  assign flush_cnt  = r_flush_cnt;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed table, hand-written
// multi-cycle sequences and randomized cycles against a behavioural model.
module tb_pipeline_hazard_ctrl;

  typedef struct packed {
    logic       pc_write;
    logic       if_id_write;
    logic       if_id_flush;
    logic       id_ex_stall;
    logic       pipe_freeze;
    logic [1:0] state;
  } ctl_t;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic       mr;
    logic       br;
    logic       mq;
    logic       my;
    ctl_t       exp;
  } vec_t;

  localparam ctl_t DEF   = 7'b11000_00;
  localparam ctl_t STALL = 7'b00010_00;
  localparam ctl_t FLUSH = 7'b11110_00;
  localparam ctl_t REDIR = 7'b11110_10;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_use_rs1, id_use_rs2, ex_memread, ex_branch_taken, mem_req, mem_ready;
  logic       pc_write, if_id_write, if_id_flush, id_ex_stall, pipe_freeze;
  logic [1:0] state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt, freeze_cnt, flush_cnt;
  int unsigned m_stall_cnt, m_freeze_cnt, m_flush_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  int m_state  = 0;
  bit m_pend   = 1'b0;
  vec_t vt[9];

  pipeline_hazard_ctrl dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .ex_rd           (ex_rd),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cnt       (stall_cnt),
    .freeze_cnt      (freeze_cnt),
    .flush_cnt       (flush_cnt),
`endif
    .pc_write        (pc_write),
    .if_id_write     (if_id_write),
    .if_id_flush     (if_id_flush),
    .id_ex_stall     (id_ex_stall),
    .pipe_freeze     (pipe_freeze),
    .state           (state)
  );

  always #5 clk = ~clk;

  function automatic ctl_t frz(input logic [1:0] s);
    ctl_t c;
    c = {5'b00001, s};
    return c;
  endfunction

  // Expected controls derived from the rules on the current inputs.
  function automatic ctl_t model_out();
    bit   hazard;
    bit   mstall;
    ctl_t o;
    hazard = ex_memread && (ex_rd != 5'd0) &&
             ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    mstall = mem_req && !mem_ready;
    o = DEF;
    if (m_state == 1) o = frz(2'd1);
    else if (m_state == 2) o = REDIR;
    else if (mstall) o = frz(2'd0);
    else if (ex_branch_taken) o = FLUSH;
    else if (hazard) o = STALL;
    return o;
  endfunction

  task automatic set_in(input logic [4:0] rs1, input logic [4:0] rs2, input logic u1,
                        input logic u2, input logic [4:0] rd, input logic mr,
                        input logic br, input logic mq, input logic my);
    id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    ex_rd = rd; ex_memread = mr; ex_branch_taken = br; mem_req = mq; mem_ready = my;
  endtask

  task automatic check_now(input string nm, input ctl_t exp);
    ctl_t act;
    act = {pc_write, if_id_write, if_id_flush, id_ex_stall, pipe_freeze, state};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got {pc,ifid_w,flush,stall,freeze,state}=%b want %b @%0t",
               nm, act, exp, $time);
    end
`ifdef HAZARD_PERF_CNT_EN
    checks++;
    if ({stall_cnt, freeze_cnt, flush_cnt} !== {m_stall_cnt, m_freeze_cnt, m_flush_cnt}) begin
      failures++;
      $display("FAIL %s_cnt: got %0d/%0d/%0d want %0d/%0d/%0d", nm, stall_cnt, freeze_cnt,
               flush_cnt, m_stall_cnt, m_freeze_cnt, m_flush_cnt);
    end
`endif
  endtask

  // Called at posedge+1 with inputs applied; checks mid-cycle then advances one clock.
  task automatic step(input string nm, input ctl_t exp);
    bit mstall;
    int n_state;
    bit n_pend;
    #4;
    check_now(nm, exp);
`ifdef HAZARD_PERF_CNT_EN
    if (exp.id_ex_stall && !exp.if_id_flush) m_stall_cnt++;
    if (exp.pipe_freeze) m_freeze_cnt++;
    if (exp.if_id_flush) m_flush_cnt++;
`endif
    mstall  = mem_req && !mem_ready;
    n_state = m_state;
    n_pend  = m_pend;
    if (m_state == 0) begin
      if (mstall) begin n_state = 1; n_pend = ex_branch_taken; end
    end else if (m_state == 1) begin
      if (mem_ready) n_state = m_pend ? 2 : 0;
    end else begin
      n_state = mstall ? 1 : 0;
      n_pend  = 1'b0;
    end
    @(posedge clk);
    #1;
    m_state = n_state;
    m_pend  = n_pend;
  endtask

  task automatic model_reset();
    m_state = 0;
    m_pend  = 1'b0;
`ifdef HAZARD_PERF_CNT_EN
    m_stall_cnt = 0; m_freeze_cnt = 0; m_flush_cnt = 0;
`endif
  endtask

  initial begin
    //         rs1    rs2    u1    u2    rd     mr    br    mq    my    exp
    vt[0] = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, STALL};
    vt[1] = '{5'd0,  5'd9,  1'b0, 1'b1, 5'd9,  1'b1, 1'b0, 1'b0, 1'b0, STALL};
    vt[2] = '{5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, DEF};
    vt[3] = '{5'd5,  5'd0,  1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, DEF};
    vt[4] = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b0, 1'b0, 1'b0, 1'b0, DEF};
    vt[5] = '{5'd5,  5'd0,  1'b1, 1'b0, 5'd5,  1'b1, 1'b1, 1'b0, 1'b0, FLUSH};
    vt[6] = '{5'd3,  5'd7,  1'b1, 1'b1, 5'd2,  1'b1, 1'b0, 1'b1, 1'b1, DEF};
    vt[7] = '{5'd4,  5'd6,  1'b1, 1'b1, 5'd5,  1'b1, 1'b0, 1'b0, 1'b0, DEF};
    vt[8] = '{5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, FLUSH};

    reset_n = 1'b0;
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    model_reset();
    #12;
    check_now("reset", DEF);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 9; i++) begin
      set_in(vt[i].rs1, vt[i].rs2, vt[i].u1, vt[i].u2, vt[i].rd, vt[i].mr,
             vt[i].br, vt[i].mq, vt[i].my);
      step($sformatf("vec%0d", i), vt[i].exp);
    end

    // Memory wait: three not-ready cycles, then ready.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("mw1", frz(2'd0));
    step("mw2", frz(2'd1));
    step("mw3", frz(2'd1));
    mem_ready = 1'b1;
    step("mw4", frz(2'd1));
    mem_req = 1'b0; mem_ready = 1'b0;
    step("mw5", DEF);

    // Branch taken on the cycle the wait starts.
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step("bw1", frz(2'd0));
    ex_branch_taken = 1'b0;
    step("bw2", frz(2'd1));
    mem_ready = 1'b1;
    step("bw3", frz(2'd1));
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    step("bw4", REDIR);
    step("bw5", DEF);

    // New memory stall during the redirect cycle.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("rm1", frz(2'd0));
    ex_branch_taken = 1'b0; mem_ready = 1'b1;
    step("rm2", frz(2'd1));
    set_in(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
    step("rm3", REDIR);
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("rm4", frz(2'd1));
    mem_ready = 1'b1;
    step("rm5", frz(2'd1));
    mem_req = 1'b0; mem_ready = 1'b0;
    step("rm6", DEF);

    // Reset asserted mid-wait with a flush pending.
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("rw1", frz(2'd0));
    set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_now("rw_async", DEF);
    #2;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    step("rw2", DEF);
    step("rw3", DEF);

    for (int i = 0; i < 400; i++) begin
      set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 2) == 0),
             1'($urandom_range(0, 1)));
      step($sformatf("rnd%0d", i), model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
